// File: rtl/mips_cpu_datapath_if.sv
// ============================================================================
// Module   : mips_cpu_datapath_if
// Brief    : Instruction-field, register-port, ALU/branch and HI/LO bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mips_cpu_datapath_if;
    logic [5:0]  i_opcode;
    logic [5:0]  i_funct;
    logic [4:0]  i_shamt;
    logic [15:0] i_imm;
    logic [4:0]  i_rs_index;
    logic [4:0]  i_rt_index;
    logic [4:0]  i_write_index;
    logic        i_write_enable;
    logic [31:0] i_write_data;
    logic        i_hilo_en;
    logic        i_div_start;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_register_v0;
    logic [31:0] o_alu_out;
    logic        o_zero;
    logic        o_branch_taken;
    logic        o_link;
    logic        o_div_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    modport master (
        output i_opcode, i_funct, i_shamt, i_imm, i_rs_index, i_rt_index,
               i_write_index, i_write_enable, i_write_data, i_hilo_en, i_div_start,
        input  o_rs_data, o_rt_data, o_register_v0, o_alu_out, o_zero,
               o_branch_taken, o_link, o_div_done, o_hi, o_lo
    );

    modport slave (
        input  i_opcode, i_funct, i_shamt, i_imm, i_rs_index, i_rt_index,
               i_write_index, i_write_enable, i_write_data, i_hilo_en, i_div_start,
        output o_rs_data, o_rt_data, o_register_v0, o_alu_out, o_zero,
               o_branch_taken, o_link, o_div_done, o_hi, o_lo
    );
endinterface

`default_nettype wire

// File: rtl/mips_cpu_datapath.sv
// ============================================================================
// Module   : mips_cpu_datapath
// Brief    : MIPS-I register file, ALU, branch unit, multiplier and
//            33-cycle iterative divider feeding HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_cpu_datapath (
    input wire clk,
    input wire rst_n,
    mips_cpu_datapath_if.slave bus
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_REGIMM  = 6'h01;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_BLEZ    = 6'h06;
    localparam logic [5:0] c_OP_BGTZ    = 6'h07;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU   = 6'h0B;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_XORI    = 6'h0E;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_SRLV  = 6'h06;
    localparam logic [5:0] c_FN_SRAV  = 6'h07;
    localparam logic [5:0] c_FN_MTHI  = 6'h11;
    localparam logic [5:0] c_FN_MTLO  = 6'h13;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    localparam logic [5:0] c_DIV_STEPS = 6'd32;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] r_regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.i_write_enable && (bus.i_write_index != 5'd0)) begin
            r_regs[bus.i_write_index] <= bus.i_write_data;
        end
    end

    logic [31:0] w_rs;
    logic [31:0] w_rt;

    assign w_rs              = (bus.i_rs_index == 5'd0) ? '0 : r_regs[bus.i_rs_index];
    assign w_rt              = (bus.i_rt_index == 5'd0) ? '0 : r_regs[bus.i_rt_index];
    assign bus.o_rs_data     = w_rs;
    assign bus.o_rt_data     = w_rt;
    assign bus.o_register_v0 = r_regs[2];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_alu;

    assign w_sext = {{16{bus.i_imm[15]}}, bus.i_imm};
    assign w_zext = {16'h0000, bus.i_imm};

    always_comb begin
        w_alu = w_rs + w_sext;
        case (bus.i_opcode)
            c_OP_SPECIAL: begin
                case (bus.i_funct)
                    c_FN_SLL:             w_alu = w_rt << bus.i_shamt;
                    c_FN_SRL:             w_alu = w_rt >> bus.i_shamt;
                    c_FN_SRA:             w_alu = $signed(w_rt) >>> bus.i_shamt;
                    c_FN_SLLV:            w_alu = w_rt << w_rs[4:0];
                    c_FN_SRLV:            w_alu = w_rt >> w_rs[4:0];
                    c_FN_SRAV:            w_alu = $signed(w_rt) >>> w_rs[4:0];
                    c_FN_ADD, c_FN_ADDU:  w_alu = w_rs + w_rt;
                    c_FN_SUB, c_FN_SUBU:  w_alu = w_rs - w_rt;
                    c_FN_AND:             w_alu = w_rs & w_rt;
                    c_FN_OR:              w_alu = w_rs | w_rt;
                    c_FN_XOR:             w_alu = w_rs ^ w_rt;
                    c_FN_NOR:             w_alu = ~(w_rs | w_rt);
                    c_FN_SLT:             w_alu = {31'd0, $signed(w_rs) < $signed(w_rt)};
                    c_FN_SLTU:            w_alu = {31'd0, w_rs < w_rt};
                    default:              w_alu = '0;
                endcase
            end
            c_OP_ADDIU: w_alu = w_rs + w_sext;
            c_OP_SLTI:  w_alu = {31'd0, $signed(w_rs) < $signed(w_sext)};
            c_OP_SLTIU: w_alu = {31'd0, w_rs < w_sext};
            c_OP_ANDI:  w_alu = w_rs & w_zext;
            c_OP_ORI:   w_alu = w_rs | w_zext;
            c_OP_XORI:  w_alu = w_rs ^ w_zext;
            c_OP_LUI:   w_alu = {bus.i_imm, 16'h0000};
            default:    w_alu = w_rs + w_sext;
        endcase
    end

    assign bus.o_alu_out = w_alu;
    assign bus.o_zero    = (w_alu == 32'd0);

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic w_taken;
    logic w_link;

    always_comb begin
        w_taken = 1'b0;
        w_link  = 1'b0;
        case (bus.i_opcode)
            c_OP_BEQ:  w_taken = (w_rs == w_rt);
            c_OP_BNE:  w_taken = (w_rs != w_rt);
            c_OP_BLEZ: w_taken = w_rs[31] || (w_rs == 32'd0);
            c_OP_BGTZ: w_taken = !w_rs[31] && (w_rs != 32'd0);
            c_OP_REGIMM: begin
                // rt_index[4] selects the linking variants, rt_index[0] picks >=0 vs <0
                case (bus.i_rt_index)
                    5'b00000: w_taken = w_rs[31];
                    5'b00001: w_taken = !w_rs[31];
                    5'b10000: begin w_taken = w_rs[31];  w_link = 1'b1; end
                    5'b10001: begin w_taken = !w_rs[31]; w_link = 1'b1; end
                    default:  w_taken = 1'b0;
                endcase
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign bus.o_branch_taken = w_taken;
    assign bus.o_link         = w_link;

    // ------------------------------------------------------------------
    // Multiplier, HI/LO and iterative restoring divider
    // ------------------------------------------------------------------
    logic [63:0] w_mult_s;
    logic [63:0] w_mult_u;

    assign w_mult_s = $signed({{32{w_rs[31]}}, w_rs}) * $signed({{32{w_rt[31]}}, w_rt});
    assign w_mult_u = {32'd0, w_rs} * {32'd0, w_rt};

    logic        w_div_start;
    logic        w_div_signed;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;

    assign w_div_start  = bus.i_div_start &&
                          ((bus.i_funct == c_FN_DIV) || (bus.i_funct == c_FN_DIVU));
    assign w_div_signed = (bus.i_funct == c_FN_DIV);
    assign w_rs_mag     = (w_div_signed && w_rs[31]) ? (~w_rs + 32'd1) : w_rs;
    assign w_rt_mag     = (w_div_signed && w_rt[31]) ? (~w_rt + 32'd1) : w_rt;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_busy;
    logic        r_div_done;
    logic [5:0]  r_div_cnt;
    logic [31:0] r_div_q;
    logic [31:0] r_div_r;
    logic [31:0] r_div_d;
    logic        r_div_negq;
    logic        r_div_negr;

    // A zero divisor always passes the compare, producing all-ones quotient
    // and the dividend as remainder without special-casing.
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_div_quot;
    logic [31:0] w_div_rem;

    assign w_div_shift = {r_div_r, r_div_q[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_div_d};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_div_d});
    assign w_div_quot  = r_div_negq ? (~r_div_q + 32'd1) : r_div_q;
    assign w_div_rem   = r_div_negr ? (~r_div_r + 32'd1) : r_div_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_busy <= 1'b0;
            r_div_done <= 1'b0;
            r_div_cnt  <= '0;
            r_div_q    <= '0;
            r_div_r    <= '0;
            r_div_d    <= '0;
            r_div_negq <= 1'b0;
            r_div_negr <= 1'b0;
        end else begin
            if (bus.i_hilo_en && (bus.i_opcode == c_OP_SPECIAL)) begin
                case (bus.i_funct)
                    c_FN_MULT:  {r_hi, r_lo} <= w_mult_s;
                    c_FN_MULTU: {r_hi, r_lo} <= w_mult_u;
                    c_FN_MTHI:  r_hi <= w_rs;
                    c_FN_MTLO:  r_lo <= w_rs;
                    default:    ;
                endcase
            end
            if (w_div_start) begin
                r_div_busy <= 1'b1;
                r_div_done <= 1'b0;
                r_div_cnt  <= '0;
                r_div_q    <= w_rs_mag;
                r_div_r    <= '0;
                r_div_d    <= w_rt_mag;
                r_div_negq <= w_div_signed && (w_rs[31] ^ w_rt[31]);
                r_div_negr <= w_div_signed && w_rs[31];
            end else if (r_div_busy) begin
                if (r_div_cnt == c_DIV_STEPS) begin
                    // Placed after the MULT/MT* update so completion wins
                    r_div_busy <= 1'b0;
                    r_div_done <= 1'b1;
                    r_lo       <= w_div_quot;
                    r_hi       <= w_div_rem;
                end else begin
                    r_div_r   <= w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
                    r_div_q   <= {r_div_q[30:0], w_div_ge};
                    r_div_cnt <= r_div_cnt + 6'd1;
                end
            end
        end
    end

    assign bus.o_hi       = r_hi;
    assign bus.o_lo       = r_lo;
    assign bus.o_div_done = r_div_done;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_datapath.sv
// ============================================================================
// Module   : tb_mips_cpu_datapath
// Brief    : Directed plus randomized bench for mips_cpu_datapath against
//            an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_cpu_datapath;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] m_regs [32];

    mips_cpu_datapath_if bus ();

    mips_cpu_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        bus.i_write_index  = idx;
        bus.i_write_data   = val;
        bus.i_write_enable = 1'b1;
        tick();
        bus.i_write_enable = 1'b0;
        if (idx != 5'd0) m_regs[idx] = val;
    endtask

    // Loads a into r8 and b into r9, then presents the instruction fields
    task automatic setup(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rsel);
        wr(5'd8, a);
        wr(5'd9, b);
        bus.i_opcode   = op;
        bus.i_funct    = fn;
        bus.i_shamt    = sh;
        bus.i_imm      = im;
        bus.i_rs_index = 5'd8;
        bus.i_rt_index = (op == 6'd1) ? rsel : 5'd9;
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [4:0] sh, input logic [15:0] im,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb, si;
        logic [31:0] se, ze;
        int amt;
        sa  = int'(a);
        sb  = int'(b);
        si  = int'($signed(im));
        se  = si;
        ze  = {16'h0000, im};
        amt = int'(a & 32'h1F);
        if (op == 6'd0) begin
            case (fn)
                6'h00: return b << sh;
                6'h02: return b >> sh;
                6'h03: return sb >>> sh;
                6'h04: return b << amt;
                6'h06: return b >> amt;
                6'h07: return sb >>> amt;
                6'h20, 6'h21: return a + b;
                6'h22, 6'h23: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (op)
            6'h0A:   return (sa < si) ? 32'd1 : 32'd0;
            6'h0B:   return (a < se) ? 32'd1 : 32'd0;
            6'h0C:   return a & ze;
            6'h0D:   return a | ze;
            6'h0E:   return a ^ ze;
            6'h0F:   return {im, 16'h0000};
            default: return a + se;
        endcase
    endfunction

    // Returns {taken, link}
    function automatic logic [1:0] ref_br(input logic [5:0] op, input logic [4:0] rsel,
                                          input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(a);
        case (op)
            6'h04: return {a == b, 1'b0};
            6'h05: return {a != b, 1'b0};
            6'h06: return {sa <= 0, 1'b0};
            6'h07: return {sa > 0, 1'b0};
            6'h01: begin
                if (rsel == 5'd0)  return {sa < 0, 1'b0};
                if (rsel == 5'd1)  return {sa >= 0, 1'b0};
                if (rsel == 5'd16) return {sa < 0, 1'b1};
                if (rsel == 5'd17) return {sa >= 0, 1'b1};
                return 2'b00;
            end
            default: return 2'b00;
        endcase
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ma, mb, q, r;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic start_div(input logic [4:0] ia, input logic [4:0] ib, input bit sgn);
        bus.i_opcode    = 6'd0;
        bus.i_funct     = sgn ? 6'h1A : 6'h1B;
        bus.i_rs_index  = ia;
        bus.i_rt_index  = ib;
        bus.i_div_start = 1'b1;
        tick();
        bus.i_div_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.o_div_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check32({tag, "_latency"}, n, 33);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [63:0] e;
        wr(5'd10, a);
        wr(5'd11, b);
        start_div(5'd10, 5'd11, sgn);
        check32("div_done_cleared", {31'd0, bus.o_div_done}, 32'd0);
        wait_done("div_rand");
        e = ref_div(a, b, sgn);
        check32("div_rand_lo", bus.o_lo, e[31:0]);
        check32("div_rand_hi", bus.o_hi, e[63:32]);
    endtask

    initial begin
        logic [31:0] a, b, v;
        logic [5:0]  op, fn;
        logic [4:0]  sh, rsel, idx;
        logic [15:0] im;
        logic [1:0]  br;
        logic [63:0] p, e;
        logic [5:0]  ops [19];
        logic [5:0]  fns [16];
        logic [4:0]  rsels [5];

        ops   = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                  6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        fns   = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                  6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        rsels = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd5};

        checks = 0;
        errors = 0;
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        rst_n              = 1'b0;
        bus.i_opcode       = '0;
        bus.i_funct        = '0;
        bus.i_shamt        = '0;
        bus.i_imm          = '0;
        bus.i_rs_index     = 5'd5;
        bus.i_rt_index     = 5'd6;
        bus.i_write_index  = '0;
        bus.i_write_enable = 1'b0;
        bus.i_write_data   = '0;
        bus.i_hilo_en      = 1'b0;
        bus.i_div_start    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("rst_hi", bus.o_hi, 32'd0);
        check32("rst_lo", bus.o_lo, 32'd0);
        check32("rst_div_done", {31'd0, bus.o_div_done}, 32'd0);
        check32("rst_v0", bus.o_register_v0, 32'd0);
        check32("rst_rs_data", bus.o_rs_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Register file basics
        wr(5'd2, 32'h1234_5678);
        wr(5'd0, 32'hFFFF_FFFF);
        bus.i_rs_index = 5'd0;
        #1;
        check32("v0", bus.o_register_v0, 32'h1234_5678);
        check32("r0_read", bus.o_rs_data, 32'd0);

        bus.i_rs_index     = 5'd2;
        bus.i_write_index  = 5'd2;
        bus.i_write_data   = 32'hCAFE_F00D;
        bus.i_write_enable = 1'b1;
        #1;
        check32("rdw_old", bus.o_rs_data, 32'h1234_5678);
        tick();
        bus.i_write_enable = 1'b0;
        m_regs[2] = 32'hCAFE_F00D;
        #1;
        check32("rdw_new", bus.o_rs_data, 32'hCAFE_F00D);

        for (int k = 0; k < 20; k++) begin
            idx = 5'($urandom_range(0, 31));
            v   = $urandom;
            wr(idx, v);
            bus.i_rs_index = 5'($urandom_range(0, 31));
            bus.i_rt_index = idx;
            #1;
            check32("rf_rs", bus.o_rs_data, m_regs[bus.i_rs_index]);
            check32("rf_rt", bus.o_rt_data, m_regs[idx]);
            check32("rf_v0", bus.o_register_v0, m_regs[2]);
        end

        // ALU directed
        setup(6'h00, 6'h21, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check32("addu_ovf", bus.o_alu_out, 32'h8000_0000);
        setup(6'h00, 6'h2A, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check32("slt", bus.o_alu_out, 32'd1);
        bus.i_funct = 6'h2B;
        #1;
        check32("sltu", bus.o_alu_out, 32'd0);
        check32("sltu_zero", {31'd0, bus.o_zero}, 32'd1);
        setup(6'h00, 6'h03, 5'd4, 16'h0, 32'd0, 32'h8000_0000, 5'd0);
        check32("sra", bus.o_alu_out, 32'hF800_0000);
        setup(6'h0F, 6'h00, 5'd0, 16'hABCD, 32'd0, 32'd0, 5'd0);
        check32("lui", bus.o_alu_out, 32'hABCD_0000);
        setup(6'h0D, 6'h00, 5'd0, 16'h8000, 32'd0, 32'd0, 5'd0);
        check32("ori", bus.o_alu_out, 32'h0000_8000);
        setup(6'h09, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0, 5'd0);
        check32("addiu", bus.o_alu_out, 32'd4);

        // Branch directed
        setup(6'h01, 6'h00, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'd0, 5'd17);
        check32("bgezal_taken", {31'd0, bus.o_branch_taken}, 32'd0);
        check32("bgezal_link", {31'd0, bus.o_link}, 32'd1);
        setup(6'h06, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0, 5'd0);
        check32("blez_zero", {31'd0, bus.o_branch_taken}, 32'd1);
        setup(6'h05, 6'h00, 5'd0, 16'h0, 32'd7, 32'd7, 5'd0);
        check32("bne_eq", {31'd0, bus.o_branch_taken}, 32'd0);

        // ALU / branch randomized
        for (int k = 0; k < 60; k++) begin
            op   = ops[$urandom_range(0, 18)];
            fn   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
            sh   = 5'($urandom);
            im   = 16'($urandom);
            a    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            rsel = rsels[$urandom_range(0, 4)];
            setup(op, fn, sh, im, a, b, rsel);
            v  = ref_alu(op, fn, sh, im, a, b);
            br = ref_br(op, rsel, a, b);
            check32("alu_rand", bus.o_alu_out, v);
            check32("zero_rand", {31'd0, bus.o_zero}, {31'd0, v == 32'd0});
            check32("br_rand", {30'd0, bus.o_branch_taken, bus.o_link}, {30'd0, br});
        end

        // Multiply and MTHI/MTLO
        setup(6'h00, 6'h18, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'd3, 5'd0);
        bus.i_hilo_en = 1'b1;
        tick();
        bus.i_hilo_en = 1'b0;
        check32("mult_hi", bus.o_hi, 32'hFFFF_FFFF);
        check32("mult_lo", bus.o_lo, 32'hFFFF_FFFA);
        bus.i_funct   = 6'h19;
        bus.i_hilo_en = 1'b1;
        tick();
        bus.i_hilo_en = 1'b0;
        check32("multu_hi", bus.o_hi, 32'd2);
        check32("multu_lo", bus.o_lo, 32'hFFFF_FFFA);
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = $urandom;
            setup(6'h00, (k % 2 == 0) ? 6'h18 : 6'h19, 5'd0, 16'h0, a, b, 5'd0);
            p = (k % 2 == 0) ? longint'(int'(a)) * longint'(int'(b)) : {32'd0, a} * {32'd0, b};
            bus.i_hilo_en = 1'b1;
            tick();
            bus.i_hilo_en = 1'b0;
            check32("mul_rand_hi", bus.o_hi, p[63:32]);
            check32("mul_rand_lo", bus.o_lo, p[31:0]);
        end
        v = $urandom;
        setup(6'h00, 6'h11, 5'd0, 16'h0, v, 32'd0, 5'd0);
        bus.i_hilo_en = 1'b1;
        tick();
        bus.i_funct = 6'h13;
        bus.i_rs_index = 5'd9;
        tick();
        bus.i_hilo_en = 1'b0;
        check32("mthi", bus.o_hi, v);
        check32("mtlo", bus.o_lo, 32'd0);

        // Divide directed: -7 / 2
        wr(5'd10, 32'hFFFF_FFF9);
        wr(5'd11, 32'd2);
        start_div(5'd10, 5'd11, 1'b1);
        repeat (32) tick();
        check32("div_early", {31'd0, bus.o_div_done}, 32'd0);
        tick();
        check32("div_done33", {31'd0, bus.o_div_done}, 32'd1);
        check32("div_lo", bus.o_lo, 32'hFFFF_FFFD);
        check32("div_hi", bus.o_hi, 32'hFFFF_FFFF);
        repeat (5) tick();
        check32("div_done_hold", {31'd0, bus.o_div_done}, 32'd1);

        run_div(32'd100, 32'd0, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_div(a, b, k[0]);
        end

        // Restart mid-divide with new operands
        wr(5'd12, 32'd1000);
        wr(5'd13, 32'd7);
        wr(5'd10, 32'h1234_5678);
        wr(5'd11, 32'd3);
        start_div(5'd10, 5'd11, 1'b0);
        repeat (10) tick();
        start_div(5'd12, 5'd13, 1'b0);
        wait_done("div_restart");
        check32("restart_lo", bus.o_lo, 32'd142);
        check32("restart_hi", bus.o_hi, 32'd6);

        // MULT during a busy divide, then completion overwrites
        wr(5'd8, 32'd6);
        wr(5'd9, 32'd7);
        start_div(5'd12, 5'd13, 1'b1);
        repeat (5) tick();
        bus.i_funct      = 6'h18;
        bus.i_rs_index   = 5'd8;
        bus.i_rt_index   = 5'd9;
        bus.i_hilo_en    = 1'b1;
        tick();
        bus.i_hilo_en    = 1'b0;
        check32("busy_mult_lo", bus.o_lo, 32'd42);
        check32("busy_mult_hi", bus.o_hi, 32'd0);
        e = ref_div(32'd1000, 32'd7, 1'b1);
        repeat (40) begin
            if (bus.o_div_done !== 1'b1) tick();
        end
        check32("overwrite_lo", bus.o_lo, e[31:0]);
        check32("overwrite_hi", bus.o_hi, e[63:32]);

        // Asynchronous reset in the middle of a divide
        start_div(5'd12, 5'd13, 1'b0);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check32("rst_mid_done", {31'd0, bus.o_div_done}, 32'd0);
        check32("rst_mid_hi", bus.o_hi, 32'd0);
        check32("rst_mid_lo", bus.o_lo, 32'd0);
        check32("rst_mid_v0", bus.o_register_v0, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        repeat (40) tick();
        check32("abort_done", {31'd0, bus.o_div_done}, 32'd0);
        check32("abort_lo", bus.o_lo, 32'd0);
        bus.i_rs_index = 5'd12;
        #1;
        check32("abort_reg", bus.o_rs_data, m_regs[12]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_cpu_datapath.md
MIPS_CPU_DATAPATH -- requirements
Module: mips_cpu_datapath

Interface
REQ-001 The block SHALL have no parameters; register count is fixed at 32 and data width at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction bits [31:26].
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 shamt  in  5  instruction bits [10:6].
REQ-007 imm  in  16  instruction bits [15:0].
REQ-008 rs_index, rt_index  in  5 each  register read addresses; rt_index also selects the REGIMM branch variant.
REQ-009 rs_data, rt_data  out  32 each  combinational register read data.
REQ-010 write_index  in  5, write_enable  in  1, write_data  in  32  register write port.
REQ-011 register_v0  out  32  continuous copy of register 2.
REQ-012 alu_out  out  32  ALU result.
REQ-013 zero  out  1  high when alu_out == 0.
REQ-014 branch_taken  out  1  branch condition true.
REQ-015 link  out  1  high for BLTZAL/BGEZAL.
REQ-016 hilo_en  in  1  enables HI/LO update for the current funct.
REQ-017 div_start  in  1  one-cycle pulse that starts a DIV/DIVU.
REQ-018 div_done  out  1  divide result valid.
REQ-019 hi, lo  out  32 each  current HI/LO contents.

Function
REQ-020 Register file: 32x32; reads are combinational; a write occurs on the rising edge when write_enable=1 and write_index!=0; register 0 always reads 0.
REQ-021 A read in the same cycle as a write to the same index SHALL return the old value; the new value is visible after the edge.
REQ-022 ALU for opcode 0: SLL/SRL/SRA shift rt by shamt; SLLV/SRLV/SRAV shift rt by rs[4:0]; ADD/ADDU = rs+rt and SUB/SUBU = rs-rt, modulo 2^32 with no overflow trap; AND, OR, XOR, NOR bitwise; SLT is a signed compare and SLTU an unsigned compare, each giving 1 or 0; all other funct values give alu_out=0.
REQ-023 ALU for I-type: ADDIU = rs+sext(imm); SLTI and SLTIU compare rs with sext(imm), signed and unsigned respectively; ANDI/ORI/XORI use zext(imm); LUI = {imm,16'h0}.
REQ-024 For loads, stores and any other opcode, alu_out SHALL be rs+sext(imm).
REQ-025 Branch conditions: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0 signed; BGTZ rs>0 signed.
REQ-026 REGIMM (opcode 1) branch conditions by rt_index: 00000 BLTZ rs<0; 00001 BGEZ rs>=0; 10000 BLTZAL rs<0; 10001 BGEZAL rs>=0.
REQ-027 link=1 for BLTZAL/BGEZAL whether or not the branch is taken; branch_taken=0 and link=0 for all non-branch opcodes.
REQ-028 HI/LO writes on the rising edge when hilo_en=1 and opcode=0: MULT writes the signed 64-bit rs*rt as {hi,lo}; MULTU writes the unsigned product; MTHI writes hi=rs; MTLO writes lo=rs.
REQ-029 Divide: div_start=1 with funct DIV/DIVU captures rs and rt and clears div_done; an iterative divider then writes lo=quotient and hi=remainder, and div_done rises exactly 33 cycles after the start edge.
REQ-030 div_done SHALL stay high until the next div_start.
REQ-031 DIV truncates the quotient toward zero and the remainder takes the sign of the dividend.
REQ-032 Divide by zero: unsigned result is quotient=32'hFFFFFFFF and remainder=dividend; signed result is the same operation applied to magnitudes, with signs fixed up per REQ-031.
REQ-033 A div_start during a busy divide SHALL restart the divide with the new operands.
REQ-034 MULT/MTHI/MTLO issued during a busy divide SHALL update HI/LO, and the divider completion SHALL overwrite them.

Reset
REQ-035 reset=0 SHALL immediately clear all 32 registers, hi, lo and div_done, and abort any divide in progress.
REQ-036 ALU outputs are combinational and are unaffected by reset.

Verification
REQ-037 Write r2=0x12345678 and r0=0xFFFFFFFF -> register_v0=0x12345678 and rs_data with rs_index=0 reads 0.
REQ-038 rs=0x7FFFFFFF, rt=1: ADDU -> 0x80000000; SLT with rs=-1, rt=1 -> 1; SLTU with the same operands -> 0; SRA with rt=0x80000000, shamt=4 -> 0xF8000000.
REQ-039 LUI imm=0xABCD -> 0xABCD0000; ORI rs=0, imm=0x8000 -> 0x00008000; ADDIU rs=5, imm=0xFFFF -> 4.
REQ-040 Branches: BGEZAL rs=-1 -> branch_taken=0, link=1; BLEZ rs=0 -> branch_taken=1; BNE rs=rt=7 -> branch_taken=0.
REQ-041 MULT rs=-2, rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=2, lo=0xFFFFFFFA.
REQ-042 DIV rs=-7, rt=2 -> after 33 cycles div_done=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF; asserting reset mid-divide -> div_done=0, hi=lo=0.
